// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master (core, host) arbiter in front of a single-port
// data memory. Grants are combinational and every access completes in its
// grant cycle. Read data is captured into the winner's rdat register and
// flagged with rvalid on the following cycle.
//
// The host can hold the memory across consecutive cycles with h_lock. To
// prevent core starvation, a wait counter forces one core grant after
// MAXWAIT denied core cycles. After that forced grant the host lock resumes.
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined   -> ties are resolved round-robin (core wins first after reset)
//   undefined -> ties always go to the core (fixed priority)
module dmem_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int MAXWAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   // core port
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdat,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdat,
   // host port
   input  logic          h_req,
   input  logic          h_we,
   input  logic          h_lock,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdat,
   output logic          h_gnt,
   output logic          h_rvalid,
   output logic [DW-1:0] h_rdat,
   // memory port
   output logic          m_wen,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdat,
   input  logic [DW-1:0] m_rdat
);

   // The wait counter is four bits wide, so the threshold is held to the same width.
   localparam logic [3:0] MAXWAIT_C = 4'(MAXWAIT);

   // The state records which master owned the memory in the previous cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CORE = 2'd1,
      HOST = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] wait_cnt_reg, wait_cnt_next;
   // This flag is set for one cycle after a forced core grant. While it is
   // set, a still-held host lock resumes even though the state is CORE.
   logic       preempt_reg, preempt_next;

   logic       lock_active;
   logic       starve;
   logic       tie_core;

   // The host lock is active when the host kept the memory in the previous
   // cycle, or lost it only to a forced core grant. It is active only while
   // the host still requests and still holds h_lock.
   assign lock_active = ((state_reg == HOST) || preempt_reg) && h_lock && h_req;

   // The core has waited long enough under the lock, so it overrides the lock.
   assign starve = lock_active && c_req && (wait_cnt_reg == MAXWAIT_C);

`ifdef DMEM_ARB_RR_EN
   // Last winner: 1 = host, 0 = core. The reset value of host lets the core win the first tie.
   logic last_host_reg;

   // Track which master won most recently. The value holds through idle cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_host_reg <= 1'b1;
      end else if (c_gnt || h_gnt) begin
         last_host_reg <= h_gnt;
      end
   end

   assign tie_core = last_host_reg;
`else
   assign tie_core = 1'b1;
`endif

   // This block holds the ownership state, the starvation counter and the preempt flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= 4'd0;
         preempt_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         preempt_reg  <= preempt_next;
      end
   end

   // This block computes the grant decision and the next state and counter values.
   always_comb begin
      c_gnt         = 1'b0;
      h_gnt         = 1'b0;
      state_next    = IDLE;
      wait_cnt_next = wait_cnt_reg;
      preempt_next  = 1'b0;

      if (!reset) begin
         if (lock_active) begin
            if (starve) begin
               c_gnt = 1'b1;
            end else begin
               h_gnt = 1'b1;
            end
         end else if (c_req && h_req) begin
            if (tie_core) begin
               c_gnt = 1'b1;
            end else begin
               h_gnt = 1'b1;
            end
         end else if (c_req) begin
            c_gnt = 1'b1;
         end else if (h_req) begin
            h_gnt = 1'b1;
         end
      end

      case (1'b1)
         c_gnt:   state_next = CORE;
         h_gnt:   state_next = HOST;
         default: state_next = IDLE;
      endcase

      // The counter restarts when the core gets in or the lock is gone.
      // It counts only the core cycles denied under the lock.
      if (c_gnt || !lock_active) begin
         wait_cnt_next = 4'd0;
      end else if (c_req) begin
         wait_cnt_next = wait_cnt_reg + 4'd1;
      end

      preempt_next = starve && !reset;
   end

   // Memory-side mux. A grant is one-hot or zero, so an AND-OR per bit is
   // enough, and an idle cycle drives zeros.
   genvar gi;
   generate
      for (gi = 0; gi < AW; gi++) begin : g_addr_mux
         assign m_addr[gi] = (c_gnt & c_addr[gi]) | (h_gnt & h_addr[gi]);
      end
      for (gi = 0; gi < DW; gi++) begin : g_wdat_mux
         assign m_wdat[gi] = (c_gnt & c_wdat[gi]) | (h_gnt & h_wdat[gi]);
      end
   endgenerate

   assign m_wen = (c_gnt & c_we) | (h_gnt & h_we);

   // Capture read data for the winning reader. The other master keeps its last read value.
   always_ff @(posedge clk) begin
      if (reset) begin
         c_rvalid <= 1'b0;
         h_rvalid <= 1'b0;
         c_rdat   <= '0;
         h_rdat   <= '0;
      end else begin
         c_rvalid <= c_gnt & ~c_we;
         h_rvalid <= h_gnt & ~h_we;
         if (c_gnt && !c_we) begin
            c_rdat <= m_rdat;
         end
         if (h_gnt && !h_we) begin
            h_rdat <= m_rdat;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test of dmem_arbiter with a behavioural
// 256x8 memory. Define DMEM_ARB_RR_EN on both the DUT and this bench to use the round-robin build.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       c_req, c_we, h_req, h_we, h_lock;
   logic [7:0] c_addr, c_wdat, h_addr, h_wdat;
   logic       c_gnt, c_rvalid, h_gnt, h_rvalid;
   logic [7:0] c_rdat, h_rdat;
   logic       m_wen;
   logic [7:0] m_addr, m_wdat, m_rdat;

   int n_cmp = 0;
   int n_err = 0;

   bit [7:0] mem [256];

   always #5 clk = ~clk;

   assign m_rdat = mem[m_addr];
   always @(posedge clk) if (m_wen) mem[m_addr] <= m_wdat;

   dmem_arbiter #(.AW(8), .DW(8), .MAXWAIT(4)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdat(c_wdat),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdat(c_rdat),
      .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdat(h_wdat),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdat(h_rdat),
      .m_wen(m_wen), .m_addr(m_addr), .m_wdat(m_wdat), .m_rdat(m_rdat)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      c_req = 0; c_we = 0; c_addr = 0; c_wdat = 0;
      h_req = 0; h_we = 0; h_lock = 0; h_addr = 0; h_wdat = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      c_req = 1; c_we = 1; c_addr = 8'h55; c_wdat = 8'hFF;
      h_req = 1; h_we = 1; h_addr = 8'h56; h_wdat = 8'hEE;
      #1;
      n_cmp++; if ({c_gnt, h_gnt} !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", {c_gnt, h_gnt}); end
      n_cmp++; if (m_wen !== 1'b0) begin n_err++; $display("FAIL rst_wen: got %b want 0", m_wen); end
      step();
      n_cmp++; if ({c_rvalid, h_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", {c_rvalid, h_rvalid}); end
      n_cmp++; if ({c_rdat, h_rdat} !== 16'h0000) begin n_err++; $display("FAIL rst_rdat: got %h want 0000", {c_rdat, h_rdat}); end
      reset = 0;
      idle_inputs();
      n_cmp++; if ({mem[8'h55], mem[8'h56]} !== 16'h0000) begin n_err++; $display("FAIL rst_nowrite: got %h want 0000", {mem[8'h55], mem[8'h56]}); end
   endtask

   task automatic test_core_rw();
      c_req = 1; c_we = 1; c_addr = 8'h10; c_wdat = 8'hA5;
      #1;
      n_cmp++; if ({c_gnt, h_gnt} !== 2'b10) begin n_err++; $display("FAIL cw_gnt: got %b want 10", {c_gnt, h_gnt}); end
      n_cmp++; if ({m_wen, m_addr, m_wdat} !== {1'b1, 8'h10, 8'hA5}) begin n_err++; $display("FAIL cw_mem: got %b/%h/%h want 1/10/a5", m_wen, m_addr, m_wdat); end
      step();
      c_we = 0; c_wdat = 8'h00;
      #1;
      n_cmp++; if ({c_gnt, h_gnt, m_wen} !== 3'b100) begin n_err++; $display("FAIL cr_gnt: got %b want 100", {c_gnt, h_gnt, m_wen}); end
      n_cmp++; if (c_rvalid !== 1'b0) begin n_err++; $display("FAIL cw_norvalid: got %b want 0", c_rvalid); end
      step();
      idle_inputs();
      c_addr = 8'h77; c_wdat = 8'h3C; c_we = 1; // unqualified, must be ignored
      #1;
      n_cmp++; if ({c_rvalid, c_rdat} !== {1'b1, 8'hA5}) begin n_err++; $display("FAIL cr_data: got %b/%h want 1/a5", c_rvalid, c_rdat); end
      n_cmp++; if (h_rvalid !== 1'b0) begin n_err++; $display("FAIL cr_hrvalid: got %b want 0", h_rvalid); end
      n_cmp++; if ({c_gnt, h_gnt, m_wen, m_addr, m_wdat} !== 19'd0) begin n_err++; $display("FAIL idle_mem: got %b%b%b/%h/%h want all 0", c_gnt, h_gnt, m_wen, m_addr, m_wdat); end
      step();
      n_cmp++; if ({c_rvalid, c_rdat} !== {1'b0, 8'hA5}) begin n_err++; $display("FAIL cr_hold: got %b/%h want 0/a5", c_rvalid, c_rdat); end
      n_cmp++; if (mem[8'h77] !== 8'h00) begin n_err++; $display("FAIL idle_nowrite: got %h want 00", mem[8'h77]); end
      idle_inputs();
   endtask

   task automatic test_tie();
      logic [1:0] exp_g, prev_g;
      reset = 1;
      step();
      reset = 0;
      c_req = 1; c_addr = 8'h10; h_req = 1; h_addr = 8'h10;
      prev_g = 2'b00;
      for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
         exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
         exp_g = 2'b10;
`endif
         #1;
         n_cmp++; if ({c_gnt, h_gnt} !== exp_g) begin n_err++; $display("FAIL tie_gnt[%0d]: got %b want %b", k, {c_gnt, h_gnt}, exp_g); end
         n_cmp++; if ({c_rvalid, h_rvalid} !== prev_g) begin n_err++; $display("FAIL tie_rvalid[%0d]: got %b want %b", k, {c_rvalid, h_rvalid}, prev_g); end
         prev_g = exp_g;
         step();
      end
      idle_inputs();
   endtask

   task automatic test_lock_burst();
      logic [1:0] exp_g;
      int hidx;
      step();
      h_req = 1; h_we = 1; h_lock = 1; h_addr = 8'h20; h_wdat = 8'h80;
      #1;
      n_cmp++; if ({c_gnt, h_gnt} !== 2'b01) begin n_err++; $display("FAIL lk_first: got %b want 01", {c_gnt, h_gnt}); end
      step();
      hidx = 1;
      c_req = 1; c_we = 0; c_addr = 8'h10;
      for (int k = 1; k <= 8; k++) begin
         h_addr = 8'h20 + 8'(hidx);
         h_wdat = 8'h80 + 8'(hidx);
         exp_g = (k == 5) ? 2'b10 : 2'b01;
         #1;
         n_cmp++; if ({c_gnt, h_gnt} !== exp_g) begin n_err++; $display("FAIL lk_gnt[%0d]: got %b want %b", k, {c_gnt, h_gnt}, exp_g); end
         if (k == 6) begin
            n_cmp++; if ({c_rvalid, c_rdat} !== {1'b1, 8'hA5}) begin n_err++; $display("FAIL lk_crd: got %b/%h want 1/a5", c_rvalid, c_rdat); end
         end
         if (exp_g == 2'b01) hidx++;
         step();
      end
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (mem[8'h20 + 8'(i)] !== 8'h80 + 8'(i)) begin n_err++; $display("FAIL lk_mem[%0d]: got %h want %h", i, mem[8'h20 + 8'(i)], 8'h80 + 8'(i)); end
      end
      n_cmp++; if (mem[8'h28] !== 8'h00) begin n_err++; $display("FAIL lk_extra: got %h want 00", mem[8'h28]); end
   endtask

   task automatic test_lock_release();
      int c_seq [13] = '{0, 1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
      int l_seq [13] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
      int e_core[13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      logic [1:0] exp_g;
      step();
      h_req = 1; h_we = 1; c_we = 0; c_addr = 8'h10;
      for (int k = 0; k < 13; k++) begin
         c_req  = c_seq[k][0];
         h_lock = l_seq[k][0];
         h_addr = 8'h40 + 8'(k);
         h_wdat = 8'(k);
         exp_g  = (e_core[k] != 0) ? 2'b10 : 2'b01;
         #1;
         n_cmp++; if ({c_gnt, h_gnt} !== exp_g) begin n_err++; $display("FAIL rel_gnt[%0d]: got %b want %b", k, {c_gnt, h_gnt}, exp_g); end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_reset_after_read();
      step();
      h_req = 1; h_we = 0; h_addr = 8'h20;
      #1;
      n_cmp++; if ({c_gnt, h_gnt} !== 2'b01) begin n_err++; $display("FAIL rr_hgnt: got %b want 01", {c_gnt, h_gnt}); end
      step();
      reset = 1;
      c_req = 1; c_we = 1; c_addr = 8'h20; c_wdat = 8'hFF;
      h_we = 1; h_wdat = 8'hFF;
      #1;
      n_cmp++; if ({c_gnt, h_gnt, m_wen} !== 3'b000) begin n_err++; $display("FAIL rr_rstgnt: got %b want 000", {c_gnt, h_gnt, m_wen}); end
      step();
      n_cmp++; if ({h_rvalid, h_rdat, c_rvalid} !== 10'd0) begin n_err++; $display("FAIL rr_cancel: got %b/%h/%b want 0/00/0", h_rvalid, h_rdat, c_rvalid); end
      n_cmp++; if (mem[8'h20] !== 8'h80) begin n_err++; $display("FAIL rr_nowrite: got %h want 80", mem[8'h20]); end
      reset = 0;
      c_we = 0; h_we = 0;
      #1;
      n_cmp++; if ({c_gnt, h_gnt} !== 2'b10) begin n_err++; $display("FAIL rr_first: got %b want 10", {c_gnt, h_gnt}); end
      step();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      step();
      step();
      test_reset();
      test_core_rw();
      test_tie();
      test_lock_burst();
      test_lock_release();
      test_reset_after_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 8, data memory address width.
REQ-002 Parameter DW, default 8, data memory word width.
REQ-003 Parameter MAXWAIT, default 4, consecutive core-blocked cycles tolerated under host lock (range 1..15).
REQ-004 Port clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Ports c_req/c_we  input  1 each  core access request / write flag.
REQ-007 Ports c_addr AW, c_wdat DW  input  core address / write data.
REQ-008 Ports c_gnt  output  1; c_rvalid  output  1; c_rdat  output  DW  core grant, read-data valid, read data.
REQ-009 Ports h_req/h_we/h_lock  input  1 each  host request, write flag, burst-lock hold.
REQ-010 Ports h_addr AW, h_wdat DW  input  host address / write data.
REQ-011 Ports h_gnt  output  1; h_rvalid  output  1; h_rdat  output  DW  host grant, read-data valid, read data.
REQ-012 Ports m_wen  output  1; m_addr  output  AW; m_wdat  output  DW; m_rdat  input  DW  memory side; memory read is combinational, write on clk edge.

Function
REQ-013 At most one of c_gnt/h_gnt SHALL be high in any cycle; grant is combinational, same cycle as request.
REQ-014 A granted access SHALL complete in that cycle: m_addr/m_wdat from winner, m_wen = winner's we.
REQ-015 No grant: m_wen=0, m_addr=0, m_wdat=0.
REQ-016 Granted read: m_rdat registered into winner's rdat; winner's rvalid high exactly one cycle, next cycle; granted write: no rvalid.
REQ-017 Non-winner rdat SHALL hold its last value.
REQ-018 FSM states IDLE, CORE, HOST; state = owner of previous cycle's grant (IDLE if none).
REQ-019 HOST->HOST lock: state HOST and h_lock and h_req -> host granted even if c_req, except REQ-021.
REQ-020 Wait counter (4 bit): +1 each cycle c_req denied under lock; cleared on any core grant or lock release.
REQ-021 Counter = MAXWAIT with c_req -> core granted that cycle regardless of lock; state -> CORE; host lock resumes next cycle if h_lock still high.
REQ-022 Host dropping h_req or h_lock ends lock immediately; normal arbitration same cycle.
REQ-023 Single requester (no lock) -> that requester granted.
REQ-024 Both requesting, no lock -> tie rule per REQ-028/029.
REQ-025 Signals not qualified by req (we, addr, wdat) SHALL be ignored.

Reset
REQ-026 reset high at clk edge: state IDLE, last-winner=HOST, counter 0, c_rvalid/h_rvalid 0, c_rdat/h_rdat 0; pending rvalid from prior cycle cancelled.
REQ-027 While reset high: c_gnt, h_gnt, m_wen 0 combinationally; no memory write occurs.

Configuration
REQ-028 DMEM_ARB_RR_EN defined: ties go to requester not granted most recently (round-robin; core first after reset).
REQ-029 DMEM_ARB_RR_EN undefined: ties always go to core (fixed priority); last-winner register not implemented; lock and REQ-021 unchanged.

Verification
REQ-030 Core write c_addr=0x10 c_wdat=0xA5, then read 0x10 -> c_gnt both cycles; c_rvalid=1, c_rdat=0xA5 cycle after read; h_rvalid stays 0.
REQ-031 RR build, both read every cycle, no lock -> grants alternate C,H,C,H from reset; no-RR build -> c_gnt every cycle, h_gnt never.
REQ-032 Host lock burst writes 0x20..0x27, c_req held, MAXWAIT=4 -> h_gnt 4 cycles, c_gnt 5th cycle, host resumes 6th; all 8 host writes land.
REQ-033 Host drops h_lock mid-burst with c_req pending -> c_gnt same cycle; counter returns 0.
REQ-034 Reset asserted the cycle after a granted host read -> h_rvalid=0, grants/m_wen 0 during reset, core granted first cycle after reset in RR build.
